// File: rtl/channel_sample_mc.sv
// Multi-channel logic-analyser front end: synchronises H/L comparator pairs, samples them
// per strobe (point or peak/glitch-capture) and packs SMPLS_PER_WORD samples per word.
module channel_sample_mc #(
    parameter int NUM_CH         = 5,
    parameter int SMPLS_PER_WORD = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               smpl_en,
    input  logic                               glitch_mode,
    input  logic [NUM_CH-1:0]                  CH_H,
    input  logic [NUM_CH-1:0]                  CH_L,
    output logic [NUM_CH-1:0]                  CH_Hff5,
    output logic [NUM_CH-1:0]                  CH_Lff5,
    output logic [NUM_CH*2*SMPLS_PER_WORD-1:0] smpl,
    output logic                               smpl_vld,
    output logic [NUM_CH-1:0]                  glitch
);

    localparam int WordW = 2 * SMPLS_PER_WORD;
    localparam int CntW  = (SMPLS_PER_WORD > 1) ? $clog2(SMPLS_PER_WORD) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SMPLS_PER_WORD - 1);

    logic [4:0][NUM_CH-1:0] h_ff_q, h_ff_d, l_ff_q, l_ff_d;

    logic [NUM_CH-1:0] acc_h_q, acc_h_d, acc_l_q, acc_l_d;
    logic [NUM_CH-1:0] seen0_q, seen0_d, seen1_q, seen1_d;
    logic              run_q, run_d;
    logic              mode_q, mode_d;

    logic [NUM_CH-1:0] h5, l5, cur_h, cur_l, cur_s0, cur_s1;
    logic [NUM_CH-1:0] smp_h, smp_l, int_glitch;
    logic              mode_eff;

    logic [NUM_CH-1:0][WordW-1:0] pack_q, pack_d, word_new;
    logic [CntW-1:0]              cnt_q, cnt_d;
    logic [NUM_CH-1:0]            gacc_q, gacc_d;
    logic [NUM_CH*WordW-1:0]      smpl_q, smpl_d;
    logic                         vld_q, vld_d;
    logic [NUM_CH-1:0]            glitch_q, glitch_d;

    always_comb begin
        h_ff_d = {h_ff_q[3:0], CH_H};
        l_ff_d = {l_ff_q[3:0], CH_L};
    end

    assign h5      = h_ff_q[4];
    assign l5      = l_ff_q[4];
    assign CH_Hff5 = h5;
    assign CH_Lff5 = l5;

    // run_q=0 marks the first cycle of an interval: accumulators restart from this cycle alone
    // and glitch_mode is taken directly from the pin, then held for the rest of the interval.
    always_comb begin
        cur_h      = run_q ? (acc_h_q | h5) : h5;
        cur_l      = run_q ? (acc_l_q & l5) : l5;
        cur_s1     = (run_q ? seen1_q : '0) | h5;
        cur_s0     = (run_q ? seen0_q : '0) | ~h5;
        mode_eff   = run_q ? mode_q : glitch_mode;
        smp_h      = mode_eff ? cur_h : h5;
        smp_l      = mode_eff ? cur_l : l5;
        int_glitch = cur_s0 & cur_s1;
    end

    always_comb begin
        acc_h_d = acc_h_q;
        acc_l_d = acc_l_q;
        seen0_d = seen0_q;
        seen1_d = seen1_q;
        mode_d  = mode_q;
        run_d   = 1'b0;
        if (!smpl_en) begin
            acc_h_d = cur_h;
            acc_l_d = cur_l;
            seen0_d = cur_s0;
            seen1_d = cur_s1;
            mode_d  = mode_eff;
            run_d   = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            logic [WordW-1:0] pair_ext;
            pair_ext      = '0;
            pair_ext[1:0] = {smp_h[i], smp_l[i]};
            word_new[i]   = (pack_q[i] << 2) | pair_ext;
        end
    end

    always_comb begin
        pack_d   = pack_q;
        cnt_d    = cnt_q;
        gacc_d   = gacc_q;
        smpl_d   = smpl_q;
        glitch_d = glitch_q;
        vld_d    = 1'b0;
        if (smpl_en) begin
            pack_d = word_new;
            if (cnt_q == CntLast) begin
                cnt_d    = '0;
                gacc_d   = '0;
                smpl_d   = word_new;
                glitch_d = gacc_q | int_glitch;
                vld_d    = 1'b1;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                gacc_d = gacc_q | int_glitch;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_ff_q   <= '0;
            l_ff_q   <= '0;
            acc_h_q  <= '0;
            acc_l_q  <= '0;
            seen0_q  <= '0;
            seen1_q  <= '0;
            run_q    <= 1'b0;
            mode_q   <= 1'b0;
            pack_q   <= '0;
            cnt_q    <= '0;
            gacc_q   <= '0;
            smpl_q   <= '0;
            vld_q    <= 1'b0;
            glitch_q <= '0;
        end else begin
            h_ff_q   <= h_ff_d;
            l_ff_q   <= l_ff_d;
            acc_h_q  <= acc_h_d;
            acc_l_q  <= acc_l_d;
            seen0_q  <= seen0_d;
            seen1_q  <= seen1_d;
            run_q    <= run_d;
            mode_q   <= mode_d;
            pack_q   <= pack_d;
            cnt_q    <= cnt_d;
            gacc_q   <= gacc_d;
            smpl_q   <= smpl_d;
            vld_q    <= vld_d;
            glitch_q <= glitch_d;
        end
    end

    assign smpl     = smpl_q;
    assign smpl_vld = vld_q;
    assign glitch   = glitch_q;

endmodule

// File: tb/tb_channel_sample_mc.sv
// Self-checking bench for channel_sample_mc: expected words are queued as stimulus is driven
// and popped by a monitor whenever smpl_vld pulses.
module tb_channel_sample_mc;

    localparam int NCH = 5;
    localparam int SPW = 4;
    localparam int SW  = NCH * 2 * SPW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           smpl_en = 1'b0;
    logic           glitch_mode = 1'b0;
    logic [NCH-1:0] ch_h = '0;
    logic [NCH-1:0] ch_l = '0;
    logic [NCH-1:0] ch_hff5, ch_lff5, glitch;
    logic [SW-1:0]  smpl;
    logic           smpl_vld;

    always #5 clk = ~clk;

    channel_sample_mc #(
        .NUM_CH         (NCH),
        .SMPLS_PER_WORD (SPW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .smpl_en     (smpl_en),
        .glitch_mode (glitch_mode),
        .CH_H        (ch_h),
        .CH_L        (ch_l),
        .CH_Hff5     (ch_hff5),
        .CH_Lff5     (ch_lff5),
        .smpl        (smpl),
        .smpl_vld    (smpl_vld),
        .glitch      (glitch)
    );

    typedef struct {
        logic [SW-1:0]  smpl;
        logic [NCH-1:0] glitch;
    } exp_t;

    typedef struct {
        logic [3:0] h;       // h[3] is the oldest sample
        logic [3:0] l;
        logic [7:0] byte_e;
        logic       g;
    } vec_t;

    exp_t sb[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;
    int   vld_cnt = 0;
    int   cyc = 0;
    int   last_vld_cyc = -1;
    bit   chk_period = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [SW-1:0] s, input logic [NCH-1:0] g);
        exp_t e;
        e.smpl   = s;
        e.glitch = g;
        sb.push_back(e);
        last_exp = e;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && smpl_vld) begin
            exp_t e;
            vld_cnt++;
            if (chk_period && last_vld_cyc >= 0) chk("vld_period", 64'(cyc - last_vld_cyc), 64'd4);
            last_vld_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vld: got smpl_vld=1 (smpl=%0h) expected 0", smpl);
            end else begin
                e = sb.pop_front();
                chk("word_smpl", 64'(smpl), 64'(e.smpl));
                chk("word_glitch", 64'(glitch), 64'(e.glitch));
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending words expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Returns at the negedge on which rst is released (first cycle of the first interval).
    task automatic do_reset(input bit mode);
        @(negedge clk);
        rst         = 1'b1;
        smpl_en     = 1'b0;
        glitch_mode = mode;
        ch_h        = '0;
        ch_l        = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pair_strobe(input logic h, input logic l);
        ch_h[0] = h;
        ch_l[0] = l;
        smpl_en = 1'b0;
        repeat (5) @(negedge clk);
        smpl_en = 1'b1;
        @(negedge clk);
        smpl_en = 1'b0;
    endtask

    // Called in the first cycle of an interval; CH_H[2] pulse reaches ff5 mid-interval,
    // well clear of the strobe cycle; glitch_mode changes to m1 after the interval start.
    task automatic slot(input bit m0, input bit pulse, input bit m1);
        glitch_mode = m0;
        smpl_en     = 1'b0;
        ch_h[2]     = pulse;
        @(negedge clk);
        ch_h[2] = 1'b0;
        @(negedge clk);
        glitch_mode = m1;
        repeat (7) @(negedge clk);
        smpl_en = 1'b1;
        @(negedge clk);
        smpl_en = 1'b0;
    endtask

    task automatic strobe_gap(input int n);
        smpl_en = 1'b0;
        repeat (n - 1) @(negedge clk);
        smpl_en = 1'b1;
        @(negedge clk);
        smpl_en = 1'b0;
    endtask

    vec_t vecs[7];
    int   v0;

    initial begin
        vecs[0] = '{h: 4'b1000, l: 4'b1101, byte_e: 8'hD1, g: 1'b1};
        vecs[1] = '{h: 4'b0000, l: 4'b0000, byte_e: 8'h00, g: 1'b0};
        vecs[2] = '{h: 4'b1111, l: 4'b1111, byte_e: 8'hFF, g: 1'b1};
        vecs[3] = '{h: 4'b1111, l: 4'b0000, byte_e: 8'hAA, g: 1'b0};
        vecs[4] = '{h: 4'b0101, l: 4'b1111, byte_e: 8'h77, g: 1'b1};
        vecs[5] = '{h: 4'b0000, l: 4'b0101, byte_e: 8'h11, g: 1'b1};
        vecs[6] = '{h: 4'b0000, l: 4'b1111, byte_e: 8'h55, g: 1'b0};

        // Reset values
        #2;
        chk("rst_smpl", 64'(smpl), 64'd0);
        chk("rst_vld", 64'(smpl_vld), 64'd0);
        chk("rst_glitch", 64'(glitch), 64'd0);

        // Continuous strobe, all comparators high
        do_reset(1'b0);
        ch_h    = '1;
        ch_l    = '1;
        smpl_en = 1'b1;
        push('0, '0);
        push({NCH{8'h3F}}, '0);
        push({NCH{8'hFF}}, '0);
        push({NCH{8'hFF}}, '0);
        v0           = vld_cnt;
        last_vld_cyc = -1;
        chk_period   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("hff5_edge4", 64'(ch_hff5), 64'd0);
        chk("lff5_edge4", 64'(ch_lff5), 64'd0);
        @(posedge clk);
        #1;
        chk("hff5_edge5", 64'(ch_hff5), 64'h1F);
        chk("lff5_edge5", 64'(ch_lff5), 64'h1F);
        repeat (11) @(posedge clk);
        @(negedge clk);
        smpl_en = 1'b0;
        drain();
        chk_period = 1'b0;
        chk("vld_count_cont", 64'(vld_cnt - v0), 64'd4);

        // Table: point sampling on channel 0
        do_reset(1'b0);
        for (int r = 0; r < 7; r++) begin
            for (int k = 3; k >= 0; k--) begin
                if (k == 0) push(SW'(vecs[r].byte_e), NCH'(vecs[r].g));
                pair_strobe(vecs[r].h[k], vecs[r].l[k]);
            end
            drain();
        end

        // Glitch capture vs point sampling of a short CH_H[2] pulse
        do_reset(1'b1);
        push(SW'(8'h20) << 16, 5'b00100);
        slot(1'b1, 1'b0, 1'b1);
        slot(1'b1, 1'b1, 1'b1);
        slot(1'b1, 1'b0, 1'b1);
        slot(1'b1, 1'b0, 1'b1);
        drain();
        push('0, 5'b00100);
        slot(1'b0, 1'b0, 1'b0);
        slot(1'b0, 1'b1, 1'b0);
        slot(1'b0, 1'b0, 1'b0);
        slot(1'b0, 1'b0, 1'b0);
        drain();

        // Mid-interval mode changes take effect from the next interval only
        push(SW'(8'h28) << 16, 5'b00100);
        slot(1'b0, 1'b1, 1'b1);
        slot(1'b1, 1'b1, 1'b1);
        slot(1'b1, 1'b1, 1'b0);
        slot(1'b0, 1'b0, 1'b0);
        drain();

        // Strobe idle: nothing emitted, word held
        repeat (50) @(negedge clk);
        chk("idle_smpl_hold", 64'(smpl), 64'(last_exp.smpl));
        chk("idle_glitch_hold", 64'(glitch), 64'(last_exp.glitch));

        // Reset in the middle of a word
        do_reset(1'b0);
        ch_h = '1;
        ch_l = '1;
        push({NCH{8'hFF}}, '1);
        repeat (4) strobe_gap(10);
        drain();
        strobe_gap(10);
        strobe_gap(10);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_smpl", 64'(smpl), 64'd0);
        chk("midrst_glitch", 64'(glitch), 64'd0);
        chk("midrst_vld", 64'(smpl_vld), 64'd0);
        chk("midrst_hff5", 64'(ch_hff5), 64'd0);
        chk("midrst_lff5", 64'(ch_lff5), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        v0  = vld_cnt;
        repeat (3) strobe_gap(10);
        chk("midrst_no_early_vld", 64'(vld_cnt - v0), 64'd0);
        push({NCH{8'hFF}}, '1);
        strobe_gap(10);
        drain();
        chk("midrst_vld_count", 64'(vld_cnt - v0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
